// File: rtl/stochastic_phase_controller.sv
// Stochastic-search phase control unit for the MCMC solver.
// Follows the top-level phase code, latches the clause mask and flip budget on
// phase entry, and runs a gain-search / flip loop until every clause is
// satisfied, the budget runs out, or the top level aborts the phase.
// State and outputs update on the falling clock edge; reset is async active-low.
module stochastic_phase_controller #(
    parameter int          MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 2,
    parameter int          ITER_WIDTH                         = 8,
    parameter logic [7:0]  SETUP_CODE                         = 8'd1,
    parameter logic [7:0]  STOCHASTIC_CODE                    = 8'd3,
    localparam int         N = 2 ** MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic [7:0]            in_current_state,
    input  logic [N-1:0]          in_clauses_enble,
    input  logic [ITER_WIDTH-1:0] in_max_iterations,
    input  logic                  in_gain_valid,
    input  logic                  in_all_satisfied,
    output logic [N-1:0]          out_clauses_enble,
    output logic                  out_find_best_gain_enable,
    output logic                  out_flip_enable,
    output logic [ITER_WIDTH-1:0] out_iteration_count,
    output logic                  out_ready,
    output logic                  out_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SEARCH = 3'd2,
        ST_FLIP   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [N-1:0]          mask_q, mask_d;
    logic [ITER_WIDTH-1:0] budget_q, budget_d;
    logic [ITER_WIDTH-1:0] cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  gain_q, flip_q, ready_q;

    logic is_setup, is_stoch;
    assign is_setup = (in_current_state == SETUP_CODE);
    assign is_stoch = (in_current_state == STOCHASTIC_CODE);

    // Next-state logic; the setup code overrides every state.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        budget_d  = budget_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (is_setup) begin
            state_d   = ST_SETUP;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_SETUP: begin
                    if (is_stoch) begin
                        // Phase entry: mask and budget are frozen until the next entry.
                        state_d   = ST_SEARCH;
                        mask_d    = in_clauses_enble;
                        budget_d  = in_max_iterations;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEARCH: begin
                    if (!is_stoch) begin
                        // Abort: counter is left as-is for debug.
                        state_d = ST_IDLE;
                    end else if (in_all_satisfied) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b0;
                    end else if (in_gain_valid) begin
                        // Count on entry to FLIP so the count is valid with the strobe.
                        state_d = ST_FLIP;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + ITER_WIDTH'(1);
                        end
                    end
                end
                ST_FLIP: begin
                    if ((budget_q != '0) && (cnt_q == budget_q)) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_DONE: begin
                    if (!is_stoch) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and Moore outputs registered from the next state on the falling edge.
    always_ff @(negedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            budget_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            gain_q    <= 1'b0;
            flip_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            budget_q  <= budget_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            gain_q    <= (state_d == ST_SEARCH);
            flip_q    <= (state_d == ST_FLIP);
            ready_q   <= (state_d == ST_DONE);
        end
    end

    assign out_clauses_enble         = mask_q;
    assign out_find_best_gain_enable = gain_q;
    assign out_flip_enable           = flip_q;
    assign out_iteration_count       = cnt_q;
    assign out_ready                 = ready_q;
    assign out_timeout               = timeout_q;

endmodule

// File: tb/tb_stochastic_phase_controller.sv
// Bench for stochastic_phase_controller (N = 4, ITER_WIDTH = 4).
// Inputs change just after the rising edge, the DUT updates on the falling
// edge, and outputs are sampled one time unit after the next rising edge.
module tb_stochastic_phase_controller;

    localparam int IW = 4;

    logic          in_clk = 1'b0;
    logic          in_rst_n;
    logic [7:0]    code;
    logic [3:0]    mask_in;
    logic [IW-1:0] bud;
    logic          gv, sat;
    logic [3:0]    o_mask;
    logic          o_gain, o_flip, o_ready, o_to;
    logic [IW-1:0] o_cnt;

    stochastic_phase_controller #(
        .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2),
        .ITER_WIDTH(IW),
        .SETUP_CODE(8'd1),
        .STOCHASTIC_CODE(8'd3)
    ) dut (
        .in_clk(in_clk),
        .in_rst_n(in_rst_n),
        .in_current_state(code),
        .in_clauses_enble(mask_in),
        .in_max_iterations(bud),
        .in_gain_valid(gv),
        .in_all_satisfied(sat),
        .out_clauses_enble(o_mask),
        .out_find_best_gain_enable(o_gain),
        .out_flip_enable(o_flip),
        .out_iteration_count(o_cnt),
        .out_ready(o_ready),
        .out_timeout(o_to)
    );

    always #5 in_clk = ~in_clk;

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_SETUP = 1, M_SEARCH = 2, M_FLIP = 3, M_DONE = 4;
    int       m_mode;
    logic [3:0] m_mask;
    int       m_budget;
    int       m_flips;   // uncapped flip count; displayed value saturates
    logic     m_to;

    int checks = 0;
    int errors = 0;

    function automatic logic [11:0] pk(input logic [3:0] m, input logic g, input logic f,
                                       input logic [3:0] c, input logic r, input logic t);
        return {m, g, f, c, r, t};
    endfunction

    function automatic logic [11:0] act_vec();
        return {o_mask, o_gain, o_flip, o_cnt, o_ready, o_to};
    endfunction

    function automatic logic [11:0] exp_vec();
        int shown;
        shown = (m_flips > 15) ? 15 : m_flips;
        return pk(m_mask, m_mode == M_SEARCH, m_mode == M_FLIP, 4'(shown),
                  m_mode == M_DONE, m_to);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_mask = '0; m_budget = 0; m_flips = 0; m_to = 1'b0;
    endtask

    task automatic model_step();
        if (code == 8'd1) begin
            m_mode = M_SETUP; m_flips = 0; m_to = 1'b0;
        end else if (m_mode == M_IDLE || m_mode == M_SETUP) begin
            if (code == 8'd3) begin
                m_mode = M_SEARCH; m_mask = mask_in; m_budget = int'(bud);
                m_flips = 0; m_to = 1'b0;
            end else m_mode = M_IDLE;
        end else if (m_mode == M_SEARCH) begin
            if (code != 8'd3) m_mode = M_IDLE;
            else if (sat) begin m_mode = M_DONE; m_to = 1'b0; end
            else if (gv) begin m_mode = M_FLIP; m_flips++; end
        end else if (m_mode == M_FLIP) begin
            if (m_budget != 0 && m_flips == m_budget) begin m_mode = M_DONE; m_to = 1'b1; end
            else m_mode = M_SEARCH;
        end else begin
            if (code != 8'd3) m_mode = M_IDLE;
        end
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b (mask,gain,flip,cnt,rdy,to)", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus, compared against the model.
    task automatic cyc(input logic [7:0] c, input logic [3:0] m, input logic [IW-1:0] b,
                       input logic g, input logic s, input string name);
        code = c; mask_in = m; bud = b; gv = g; sat = s;
        @(negedge in_clk);
        if (!in_rst_n) model_reset(); else model_step();
        @(posedge in_clk); #1;
        check(name, act_vec(), exp_vec());
    endtask

    task automatic do_reset();
        in_rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_async", act_vec(), 12'h000);
        @(posedge in_clk); #1;
        in_rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]    code;
        logic [3:0]    mask;
        logic [IW-1:0] bud;
        logic          gv;
        logic          sat;
        logic [11:0]   exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        // Budget exhaustion: mask 1011, budget 3, gain pulsed in every SEARCH cycle.
        tbl[0] = '{8'd3, 4'b1011, 4'd3, 1'b0, 1'b0, pk(4'b1011, 1, 0, 4'd0, 0, 0)};
        tbl[1] = '{8'd3, 4'b1011, 4'd3, 1'b1, 1'b0, pk(4'b1011, 0, 1, 4'd1, 0, 0)};
        tbl[2] = '{8'd3, 4'b1011, 4'd3, 1'b0, 1'b0, pk(4'b1011, 1, 0, 4'd1, 0, 0)};
        tbl[3] = '{8'd3, 4'b1011, 4'd3, 1'b1, 1'b0, pk(4'b1011, 0, 1, 4'd2, 0, 0)};
        tbl[4] = '{8'd3, 4'b1011, 4'd3, 1'b0, 1'b0, pk(4'b1011, 1, 0, 4'd2, 0, 0)};
        tbl[5] = '{8'd3, 4'b1011, 4'd3, 1'b1, 1'b0, pk(4'b1011, 0, 1, 4'd3, 0, 0)};
        tbl[6] = '{8'd3, 4'b1011, 4'd3, 1'b0, 1'b0, pk(4'b1011, 0, 0, 4'd3, 1, 1)};
        tbl[7] = '{8'd3, 4'b0000, 4'd9, 1'b1, 1'b0, pk(4'b1011, 0, 0, 4'd3, 1, 1)};
        tbl[8] = '{8'd1, 4'b0000, 4'd9, 1'b0, 1'b0, pk(4'b1011, 0, 0, 4'd0, 0, 0)};
        tbl[9] = '{8'd0, 4'b0000, 4'd9, 1'b0, 1'b0, pk(4'b1011, 0, 0, 4'd0, 0, 0)};

        in_rst_n = 1'b0; code = 8'd0; mask_in = '0; bud = '0; gv = 1'b0; sat = 1'b0;
        model_reset();
        repeat (2) @(posedge in_clk);
        #1;
        check("reset_state", act_vec(), 12'h000);
        in_rst_n = 1'b1;

        // Table-driven budget exhaustion
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].code, tbl[i].mask, tbl[i].bud, tbl[i].gv, tbl[i].sat, "tbl_model");
            check($sformatf("tbl_row%0d", i), act_vec(), tbl[i].exp);
            if (i < 7 && o_flip) strobes++;
        end
        check("budget_strobes", 12'(strobes), 12'd3);

        // Reset between edges while in FLIP
        do_reset();
        cyc(8'd3, 4'b1111, 4'd5, 1'b0, 1'b0, "rst_flip_a");
        cyc(8'd3, 4'b1111, 4'd5, 1'b1, 1'b0, "rst_flip_b");
        check("rst_in_flip", act_vec(), pk(4'b1111, 0, 1, 4'd1, 0, 0));
        #2 in_rst_n = 1'b0;
        #1 model_reset();
        check("rst_mid_flip", act_vec(), 12'h000);
        cyc(8'd3, 4'b1111, 4'd5, 1'b1, 1'b0, "rst_held");
        in_rst_n = 1'b1;

        // Early satisfaction together with the 2nd gain pulse; then setup override from DONE
        do_reset();
        cyc(8'd3, 4'b1111, 4'd10, 1'b0, 1'b0, "early_a");
        cyc(8'd3, 4'b1111, 4'd10, 1'b1, 1'b0, "early_b");
        cyc(8'd3, 4'b1111, 4'd10, 1'b0, 1'b0, "early_c");
        cyc(8'd3, 4'b1111, 4'd10, 1'b1, 1'b1, "early_d");
        check("early_done", act_vec(), pk(4'b1111, 0, 0, 4'd1, 1, 0));
        cyc(8'd3, 4'b1111, 4'd10, 1'b1, 1'b0, "early_e");
        check("early_no_strobe", act_vec(), pk(4'b1111, 0, 0, 4'd1, 1, 0));
        cyc(8'd1, 4'b1111, 4'd10, 1'b0, 1'b0, "done_setup");
        check("done_to_setup", act_vec(), pk(4'b1111, 0, 0, 4'd0, 0, 0));

        // Timeout then setup override clears ready and timeout
        cyc(8'd3, 4'b0110, 4'd1, 1'b0, 1'b0, "to_a");
        cyc(8'd3, 4'b0110, 4'd1, 1'b1, 1'b0, "to_b");
        cyc(8'd3, 4'b0110, 4'd1, 1'b0, 1'b0, "to_c");
        check("budget1_timeout", act_vec(), pk(4'b0110, 0, 0, 4'd1, 1, 1));
        cyc(8'd1, 4'b0110, 4'd1, 1'b0, 1'b0, "to_setup");
        check("timeout_cleared", act_vec(), pk(4'b0110, 0, 0, 4'd0, 0, 0));

        // Unbounded budget: 20 flips saturate the 4-bit counter at 15
        do_reset();
        cyc(8'd3, 4'b0101, 4'd0, 1'b0, 1'b0, "unb_enter");
        for (int k = 0; k < 20; k++) begin
            cyc(8'd3, 4'b0101, 4'd0, 1'b1, 1'b0, "unb_flip");
            cyc(8'd3, 4'b0101, 4'd0, 1'b0, 1'b0, "unb_search");
        end
        check("unbounded_sat", act_vec(), pk(4'b0101, 1, 0, 4'd15, 0, 0));

        // Abort from SEARCH: counter held, ready stays low
        cyc(8'd2, 4'b0101, 4'd0, 1'b0, 1'b0, "abort");
        check("abort_idle", act_vec(), pk(4'b0101, 0, 0, 4'd15, 0, 0));

        // Mask freeze
        cyc(8'd3, 4'b1111, 4'd5, 1'b0, 1'b0, "frz_a");
        cyc(8'd3, 4'b0001, 4'd5, 1'b1, 1'b0, "frz_b");
        cyc(8'd3, 4'b0001, 4'd5, 1'b0, 1'b0, "frz_c");
        check("mask_frozen", act_vec(), pk(4'b1111, 1, 0, 4'd1, 0, 0));
        cyc(8'd0, 4'b0001, 4'd5, 1'b0, 1'b0, "frz_d");
        cyc(8'd3, 4'b0001, 4'd5, 1'b0, 1'b0, "frz_e");
        check("mask_relatch", act_vec(), pk(4'b0001, 1, 0, 4'd0, 0, 0));

        // Randomised run against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 15);
            if (r < 11)       c = 8'd3;
            else if (r < 13)  c = 8'd1;
            else if (r == 13) c = 8'd0;
            else if (r == 14) c = 8'd2;
            else              c = 8'hA5;
            if ($urandom_range(0, 199) == 0) in_rst_n = 1'b0;
            cyc(c, 4'($urandom), 4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) == 0, $sformatf("rand%0d", n));
            in_rst_n = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stochastic_phase_controller.md
Name: stochastic_phase_controller

Overview:
- Parametrised control unit for the stochastic-search phase of the MCMC solver.
- Tracks the top-level phase code and gates the clause set into the find-best-gain datapath.
- Runs a bounded gain-search / flip iteration loop and reports completion, or timeout, back to the top-level FSM.
- Successor to the fixed 2-bit-clause-index stochastic control unit. Adds an iteration budget, a gain handshake, early exit on full satisfaction, an abort path and an asynchronous reset.

Parameters:
- MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX, 2, number of clause slots is N = 2**MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX.
- ITER_WIDTH, 8, width of the iteration budget and the iteration counter.
- SETUP_CODE, 1, top-level phase code for setup.
- STOCHASTIC_CODE, 3, top-level phase code for stochastic search.

Ports:
- in_clk, input, 1, clock. All state updates occur on the negedge, as in the other control units.
- in_rst_n, input, 1, asynchronous active-low reset.
- in_current_state, input, 8, top-level phase code.
- in_clauses_enble, input, N, existing-clause mask.
- in_max_iterations, input, ITER_WIDTH, flip budget. A value of 0 means unbounded.
- in_gain_valid, input, 1, find-best-gain result is valid (single-cycle pulse).
- in_all_satisfied, input, 1, checker reports that every enabled clause is satisfied.
- out_clauses_enble, output, N, latched clause mask driven to the datapath.
- out_find_best_gain_enable, output, 1, runs the gain search.
- out_flip_enable, output, 1, single-cycle strobe to commit the best-gain flip.
- out_iteration_count, output, ITER_WIDTH, number of flips done in the current phase.
- out_ready, output, 1, stochastic phase finished.
- out_timeout, output, 1, the phase finished because the budget was exhausted.

Behaviour:
- Reset (in_rst_n = 0, takes effect immediately, regardless of clock):
  - state is IDLE;
  - all outputs are 0;
  - latched mask, latched budget and counter are 0.
- State encoding: IDLE = 0, SETUP = 1, SEARCH = 2, FLIP = 3, DONE = 4, on a 3-bit register.
- Outputs are registered and Moore-style, derived from the next state, so they are valid in the same cycle the state is.
- Global priority: in_current_state == SETUP_CODE forces SETUP from any state. This overrides all other conditions except reset.
- IDLE:
  - If the code is STOCHASTIC_CODE, go to SEARCH. On the same edge, latch in_clauses_enble and in_max_iterations, clear the counter and clear out_timeout.
  - Otherwise stay in IDLE.
- SETUP:
  - Counter, out_ready and out_timeout are cleared.
  - If the code is STOCHASTIC_CODE, go to SEARCH and latch as in IDLE.
  - If the code is SETUP_CODE, stay in SETUP.
  - Otherwise go to IDLE.
- SEARCH:
  - Drives out_find_best_gain_enable = 1 and out_clauses_enble = latched mask.
  - If the code is neither SETUP_CODE nor STOCHASTIC_CODE, abort to IDLE. out_ready stays 0 and the counter is held for debug.
  - Otherwise, if in_all_satisfied, go to DONE with out_timeout = 0. This takes priority over in_gain_valid in the same cycle, and no flip occurs.
  - Otherwise, if in_gain_valid, go to FLIP.
  - Otherwise stay in SEARCH. There is no internal timeout on the handshake.
- FLIP:
  - out_flip_enable = 1 for exactly one cycle.
  - out_find_best_gain_enable = 0.
  - The counter increments. With a budget of 0 the counter saturates at all-ones and does not wrap.
  - If the budget is nonzero and the counter after increment equals the budget, go to DONE with out_timeout = 1.
  - Otherwise return to SEARCH.
- DONE:
  - out_ready = 1; out_timeout and the counter are held; the gain and flip enables are 0.
  - If the code is STOCHASTIC_CODE, stay in DONE.
  - If the code is SETUP_CODE, go to SETUP.
  - Otherwise go to IDLE, where out_ready drops.
- The latched mask is frozen for the whole phase. Changes on in_clauses_enble during SEARCH/FLIP are ignored.
- Minimum flip-loop latency: one cycle in SEARCH with in_gain_valid, then one cycle in FLIP. That gives one flip per 2 cycles.

Test Plan:
- Reset mid-FLIP: assert in_rst_n = 0 between edges. All outputs go to 0 immediately, state is IDLE, and out_flip_enable never completes its cycle.
- Budget exhaustion: N = 4, mask 4'b1011, budget 3, in_gain_valid pulsed every SEARCH cycle, in_all_satisfied = 0. Required: exactly 3 out_flip_enable strobes, count = 3, out_ready = 1 and out_timeout = 1, out_clauses_enble = 4'b1011 throughout.
- Early satisfaction: budget 10, in_all_satisfied = 1 at the same time as the 2nd in_gain_valid. Required: DONE after 1 flip, count = 1, out_timeout = 0, no 2nd strobe.
- Unbounded: ITER_WIDTH = 4, budget 0, 20 gain pulses. Required: count saturates at 15, no timeout, still in SEARCH.
- Abort and setup override:
  - code changes 3 to 2 during SEARCH: IDLE, out_ready = 0;
  - code 1 while in DONE: SETUP, with out_ready and out_timeout cleared.
- Mask freeze: change in_clauses_enble from 4'b1111 to 4'b0001 during SEARCH. Required: out_clauses_enble stays 4'b1111 until the next phase entry.
